// File: rtl/pp_buffer_ctrl.sv
// Ping-pong buffer controller: fills one bank from a valid/ready stream, swaps banks,
// streams the other bank out. Optional early frame close via in_last when PP_CTRL_FLUSH_EN is defined.
module pp_buffer_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  buf_ctrl,
  output logic                  buf_wr_en,
  output logic [ADDR_WIDTH-1:0] buf_wr_addr,
  output logic [DATA_WIDTH-1:0] buf_din,
  output logic                  buf_rd_en,
  output logic [ADDR_WIDTH-1:0] buf_rd_addr,
  input  logic [DATA_WIDTH-1:0] buf_dout,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] ONE      = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] LAST_IDX = (ADDR_WIDTH+1)'(DEPTH - 1);

  logic [ADDR_WIDTH:0] wr_cnt;
  logic                wr_full;
  logic [ADDR_WIDTH:0] frame_len;
  logic                ctrl;
  logic                rd_busy;
  logic [ADDR_WIDTH:0] rd_cnt;
  logic [ADDR_WIDTH:0] rd_len;
  logic                vld_p1, vld_p2;
  logic                last_p1, last_p2;

  logic accept, close_frame, swap, rd_end;

  assign in_ready = !wr_full;
  assign accept   = in_valid && !wr_full;

`ifdef PP_CTRL_FLUSH_EN
  assign close_frame = accept && ((wr_cnt == LAST_IDX) || in_last);
`else
  logic unused_in_last;
  assign unused_in_last = in_last;
  assign close_frame    = accept && (wr_cnt == LAST_IDX);
`endif

  // Swap waits on the registered rd_busy, so the old bank is never read in the swap cycle.
  assign swap   = wr_full && !rd_busy;
  assign rd_end = rd_busy && (rd_cnt == rd_len - ONE);

  assign buf_ctrl    = ctrl;
  assign buf_wr_en   = accept;
  assign buf_wr_addr = wr_cnt[ADDR_WIDTH-1:0];
  assign buf_din     = in_data;
  assign buf_rd_en   = rd_busy;
  assign buf_rd_addr = rd_cnt[ADDR_WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt    <= '0;
      wr_full   <= 1'b0;
      frame_len <= '0;
      ctrl      <= 1'b0;
    end else if (swap) begin
      ctrl    <= ~ctrl;
      wr_full <= 1'b0;
      wr_cnt  <= '0;
    end else if (accept) begin
      wr_cnt <= wr_cnt + ONE;
      if (close_frame) begin
        wr_full   <= 1'b1;
        frame_len <= wr_cnt + ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_busy <= 1'b0;
      rd_cnt  <= '0;
      rd_len  <= '0;
    end else if (swap) begin
      rd_busy <= 1'b1;
      rd_cnt  <= '0;
      rd_len  <= frame_len;
    end else if (rd_busy) begin
      rd_cnt <= rd_cnt + ONE;
      if (rd_end) rd_busy <= 1'b0;
    end
  end

  // p1/p2: match the buffer's two-cycle read latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      vld_p2  <= 1'b0;
      last_p2 <= 1'b0;
    end else begin
      vld_p1  <= rd_busy;
      last_p1 <= rd_end;
      vld_p2  <= vld_p1;
      last_p2 <= last_p1;
    end
  end

  assign out_valid = vld_p2;
  assign out_last  = last_p2;
  assign out_data  = buf_dout;
  assign busy      = (wr_cnt != '0) || wr_full || rd_busy || vld_p1 || vld_p2;
endmodule

// File: tb/tb_pp_buffer_ctrl.sv
// Scoreboard bench for pp_buffer_ctrl with a two-bank buffer model (2-cycle read latency).
module tb_pp_buffer_ctrl;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DEPTH = 2**AW;
`ifdef PP_CTRL_FLUSH_EN
  localparam bit FLUSH = 1'b1;
`else
  localparam bit FLUSH = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic          buf_ctrl, buf_wr_en, buf_rd_en;
  logic [AW-1:0] buf_wr_addr, buf_rd_addr;
  logic [DW-1:0] buf_din, buf_dout, out_data;
  logic          out_valid, out_last, busy;

  pp_buffer_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .buf_ctrl(buf_ctrl), .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr), .buf_din(buf_din),
    .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr), .buf_dout(buf_dout),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  // Two-bank memory: buf_ctrl=1 writes bank index 1 and reads bank index 0.
  logic [DW-1:0] mem [2][DEPTH];
  logic [DW-1:0] rd_q1 = '0;
  initial begin
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < DEPTH; i++) mem[b][i] = '0;
    buf_dout = '0;
  end
  always @(posedge clk) begin
    if (buf_wr_en) mem[buf_ctrl ? 1 : 0][buf_wr_addr] <= buf_din;
    rd_q1    <= mem[buf_ctrl ? 0 : 1][buf_rd_addr];
    buf_dout <= rd_q1;
  end

  typedef struct { logic [DW-1:0] d; logic l; } exp_t;
  exp_t sb[$];
  int   pos = 0;
  int   checks = 0, failures = 0;
  int   cyc = 0, stalls = 0, out_cnt = 0, toggles = 0;
  logic prev_ctrl = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (buf_ctrl !== prev_ctrl) toggles++;
    prev_ctrl = buf_ctrl;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expected word per presented output.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL spurious_out: got data %0h with empty scoreboard", out_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_data", 32'(out_data), 32'(e.d));
        chk("out_last", 32'(out_last), 32'(e.l));
        out_cnt++;
      end
    end
  end

  // Called at a negedge; returns at the negedge after the word is accepted.
  task automatic send(input logic [DW-1:0] d, input logic l);
    int guard = 0;
    exp_t e;
    in_valid = 1'b1; in_data = d; in_last = l;
    while (!in_ready && guard < 300) begin
      stalls++; guard++;
      @(negedge clk);
    end
    if (guard >= 300) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    e.d = d;
    e.l = (pos == DEPTH-1) || (FLUSH && l);
    sb.push_back(e);
    pos = e.l ? 0 : pos + 1;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || sb.size() != 0) && n < 500) begin n++; @(negedge clk); end
    chk("drain_busy", 32'(busy), 32'd0);
    chk("drain_pending", 32'(sb.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_state();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_buf_ctrl", 32'(buf_ctrl), 32'd0);
    chk("rst_wr_en", 32'(buf_wr_en), 32'd0);
    chk("rst_rd_en", 32'(buf_rd_en), 32'd0);
    chk("rst_wr_addr", 32'(buf_wr_addr), 32'd0);
    chk("rst_rd_addr", 32'(buf_rd_addr), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int t0, n, target;
    repeat (3) @(negedge clk);
    check_reset_state();
    rst_n = 1'b1;
    @(negedge clk);

    // One full frame 0x00..0x0F: latency and bank toggle
    t0 = cyc;
    for (int i = 0; i < DEPTH; i++) send(DW'(i), 1'b0);
    chk("busy_after_frame", 32'(busy), 32'd1);
    n = 0;
    while (!out_valid && n < 50) begin n++; @(negedge clk); end
    chk("first_out_latency", 32'(cyc - t0), 32'(DEPTH + 3));
    chk("buf_ctrl_after_swap", 32'(buf_ctrl), 32'd1);
    wait_idle();

    // 48 continuous words: one bubble before each following frame, three swaps
    stalls = 0; toggles = 0;
    for (int i = 0; i < 3*DEPTH; i++) send(DW'($urandom), 1'b0);
    chk("continuous_stalls", 32'(stalls), 32'd2);
    wait_idle();
    chk("continuous_toggles", 32'(toggles), 32'd3);

    if (FLUSH) begin
      // Short frame fills while a full frame is still being read
      stalls = 0;
      for (int i = 0; i < DEPTH; i++) send(DW'($urandom), 1'b0);
      for (int i = 0; i < 3; i++) send(DW'($urandom), i == 2);
      for (int i = 0; i < 4; i++) send(DW'($urandom), i == 3);
      chk("held_ready_stalls", 32'(stalls), 32'd15);
      wait_idle();
      // Five-word frame, next frame restarts at address 0
      for (int i = 0; i < 5; i++) send(DW'(8'hA0 + i), i == 4);
      wait_idle();
      chk("flush_next_addr", 32'(buf_wr_addr), 32'd0);
      for (int i = 0; i < DEPTH; i++) send(DW'($urandom), 1'b0);
      wait_idle();
    end

    // Reset in the middle of reading frame 2
    target = out_cnt + DEPTH + 4;
    for (int i = 0; i < 2*DEPTH; i++) send(DW'($urandom), 1'b0);
    n = 0;
    while (out_cnt < target && n < 200) begin n++; @(negedge clk); end
    chk("mid_read_reached", 32'(out_cnt >= target), 32'd1);
    rst_n = 1'b0;
    sb.delete();
    pos = 0;
    #1;
    check_reset_state();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < DEPTH; i++) send(DW'(8'h40 + i), 1'b0);
    wait_idle();

    // Random gaps (and random early closes when enabled) over ten frames
    for (int i = 0; i < 10*DEPTH; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(DW'($urandom), ($urandom_range(0, 7) == 0));
    end
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
